muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide sequencer. Sits in the EX stage beside the ALU.
- Accepts one M-extension operation from ID/EX, runs a shift-add or restoring-divide loop over XLEN cycles, and returns a single result.
- Holds the pipeline stalled via `stall` until the result is ready, then pulses `done` so EX/MEM captures `result`.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_sign_fix.sv | 18 +
 rtl/muldiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and operand signedness decode.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of the finished product, quotient or remainder.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    always_comb begin
        val_o = val_i;
        if (neg_i) begin
            val_o = ~val_i + W'(1);
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle product in PREP.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// PREP  | magnitudes, sign flags, counter load; divide fast paths jump to FIN
// CALC  | one product/quotient bit per cycle for XLEN cycles
// FIN   | sign correction, result select, done pulse
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN:0]     acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                neg_a, neg_b;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                is_div, div_zero, div_ovf;
    logic [XLEN:0]       mul_sum;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;
    logic [XLEN-1:0]     fin_val;

    assign is_div   = f3_q[2];
    assign neg_a    = op_signed_a(f3_q) & a_q[XLEN-1];
    assign neg_b    = op_signed_b(f3_q) & b_q[XLEN-1];
    assign div_zero = is_div & (b_q == '0);
    // Only DIV/REM are signed divides, which is exactly is_div with a signed dividend.
    assign div_ovf  = is_div & op_signed_a(f3_q) & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);

    muldiv_sign_fix #(.W(XLEN)) u_fix_a (.val_i(a_q), .neg_i(neg_a), .val_o(abs_a));
    muldiv_sign_fix #(.W(XLEN)) u_fix_b (.val_i(b_q), .neg_i(neg_b), .val_o(abs_b));

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .val_i(acc_q[2*XLEN-1:0]), .neg_i(neg_q), .val_o(prod_fix)
    );
    muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
        .val_i(acc_q[XLEN-1:0]), .neg_i(neg_q), .val_o(quo_fix)
    );
    muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
        .val_i(acc_q[2*XLEN-1:XLEN]), .neg_i(neg_rem_q), .val_o(rem_fix)
    );

    // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
    assign mul_sum  = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    // Divide step: trial-subtract the divisor from the left-shifted partial remainder.
    assign div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, mcand_q};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
    assign prod_fast = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

    always_comb begin
        fin_val = rem_fix;
        case (f3_q)
            F3_MUL:                       fin_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_val = quo_fix;
            default:                      fin_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        stall     = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                stall = start;
                if (start && !flush) begin
                    f3_d    = funct3;
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = PREP;
                end
            end
            PREP: begin
                stall     = 1'b1;
                neg_d     = neg_a ^ neg_b;
                neg_rem_d = neg_a;
                mcand_d   = abs_b;
                acc_d     = {{(XLEN+1){1'b0}}, abs_a};
                cnt_d     = CNT_W'(XLEN);
                state_d   = CALC;
                // Fast-path values are already final, so sign correction is disabled.
                if (div_zero) begin
                    acc_d     = {1'b0, a_q, {XLEN{1'b1}}};
                    neg_d     = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = FIN;
                end else if (div_ovf) begin
                    acc_d     = {1'b0, {XLEN{1'b0}}, a_q};
                    neg_d     = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = FIN;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!is_div) begin
                    acc_d   = {1'b0, prod_fast};
                    state_d = FIN;
                end
`endif
            end
            CALC: begin
                stall = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div) begin
                    if (!div_diff[XLEN+1]) begin
                        acc_d = {div_diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*XLEN-1:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done     = 1'b1;
                result_d = fin_val;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An aborted operation must leave no trace on done or result.
        if (flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            done     = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign result = done ? fin_val : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results and
// done cycles, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        logic [31:0] res;
        int unsigned due;
        logic [2:0]  f3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, flush, busy, stall, done;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            MUL:    begin p = ua * ub; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sa / sb; return sq[31:0];
            end
            DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sq = sa % sb; return sq[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < DIV) return MUL_LAT;
        if (b == 0) return 2;
        if ((f3 == DIV || f3 == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%h, expected no done", result);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("result_f3_%0d", mon_e.f3), result, mon_e.res);
                check($sformatf("done_cycle_f3_%0d", mon_e.f3), cyc, mon_e.due);
            end
        end
    end

    // Call between a negedge and the following posedge; returns just after the sampling edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        if (push) begin
            e.res = ref_op(f3, a, b);
            e.due = cyc + lat_of(f3, a, b);
            e.f3  = f3;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) break;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int          sc;
        int unsigned d0;
        exp_t        e;

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_stall", stall, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_busy", busy, 0);

        // MUL 7 x 6 with stall cycle count
        funct3 = MUL; op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        e.res = 32'd42; e.due = cyc + MUL_LAT; e.f3 = MUL;
        exp_q.push_back(e);
        #1 sc = stall ? 1 : 0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                check("stall_in_done", stall, 0);
                break;
            end
            if (stall) sc++;
        end
        check("mul_stall_cycles", sc, MUL_LAT);
        wait_idle();

        start_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
        start_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
        start_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
        start_op(DIV,    32'hFFFF_FFF9, 32'd2, 1);         wait_idle();
        start_op(REM,    32'hFFFF_FFF9, 32'd2, 1);         wait_idle();

        // flush mid-operation: result keeps the REM value 0xFFFFFFFF
        d0 = done_cnt;
        start_op(DIVU, 32'd1000, 32'd3, 0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_stall", stall, 0);
        check("flush_result_kept", result, 32'hFFFF_FFFF);
        start_op(REMU, 32'd1000, 32'd3, 1);
        wait_idle();
        check("flush_done_count", done_cnt - d0, 1);

        start_op(DIVU, 32'd100, 32'd0, 1);                 wait_idle();
        start_op(REMU, 32'd100, 32'd0, 1);                 wait_idle();
        start_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);   wait_idle();
        start_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1);   wait_idle();
        start_op(REM,  32'hFFFF_FFF9, 32'd0, 1);           wait_idle();

        // start pulses during CALC must be ignored
        d0 = done_cnt;
        start_op(DIVU, 32'd123456, 32'd789, 1);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            funct3 = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("ignored_start_done_count", done_cnt - d0, 1);

        #1;
        for (int i = 0; i < 40; i++) begin
            start_op(3'($urandom_range(0, 7)), pick(), pick(), 1);
            wait_idle();
        end

        // async reset between clock edges
        start_op(DIVU, 32'd12345, 32'd7, 1);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_stall", stall, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        start_op(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
